// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard controller.
// Holds the operand-mux select encodings, the register-index width, the
// in-flight slot record and the slot match helper.
package fwd_pkg;

  // Register index width (32 architectural registers, x0 hard-wired zero)
  localparam int FWD_REG_AW = 5;

  // EX operand mux op encodings
  localparam logic [1:0] FWD_RF    = 2'd0;  // register file value
  localparam logic [1:0] FWD_EXMEM = 2'd1;  // EX/MEM pipeline result
  localparam logic [1:0] FWD_MEMWB = 2'd2;  // MEM/WB pipeline result
  localparam logic [1:0] FWD_ALT   = 2'd3;  // PC (operand A) or immediate (operand B)

  // One tracked instruction in flight
  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic                  wen;
    logic                  is_load;
  } slot_t;

  // A slot produces rs if it is live, writes, targets rs, and rs is not x0
  function automatic logic slot_hit(input slot_t s, input logic [FWD_REG_AW-1:0] rs);
    return s.valid && s.wen && (s.rd != '0) && (s.rd == rs);
  endfunction

  // A select that pulls a value from a pipeline register instead of the file
  function automatic logic is_fwd(input logic [1:0] sel);
    return (sel == FWD_EXMEM) || (sel == FWD_MEMWB);
  endfunction

endpackage

// File: rtl/fwd_pick.sv
// Per-operand forwarding select. Pure combinational: given a source
// register and whether the operand uses its alternate input (PC or
// immediate), chooses the mux op and flags a load-use dependency on EX.
module fwd_pick
  import fwd_pkg::*;
(
  input  logic [FWD_REG_AW-1:0] rs,
  input  logic                  use_alt,
  input  slot_t                 ex_slot,
  input  slot_t                 mem_slot,
  output logic [1:0]            sel,
  output logic                  load_hit
);

  // Nearer producer (EX) wins over MEM; alternate input bypasses tracking
  always_comb begin
    sel      = FWD_RF;
    load_hit = 1'b0;
    if (use_alt) begin
      sel = FWD_ALT;
    end else if (slot_hit(ex_slot, rs)) begin
      sel      = FWD_EXMEM;
      load_hit = ex_slot.is_load;
    end else if (slot_hit(mem_slot, rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks destinations in EX and MEM, registers the EX operand mux selects
// at each ID->EX advance, and stalls IF/ID one cycle on a load-use hazard.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = FWD_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              id_a_pc,
  input  logic              id_b_imm,
  output logic              stall,
  output logic              ex_valid,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_stalls,
  output logic [CNT_W-1:0]  stat_fwds
`endif
);

  slot_t      ex_q, ex_d;
  slot_t      mem_q, mem_d;
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;

  logic [1:0] pick_a, pick_b;
  logic       load_hit_a, load_hit_b;
  logic       bubble;

  fwd_pick u_pick_a (
    .rs       (id_rs1),
    .use_alt  (id_a_pc),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (pick_a),
    .load_hit (load_hit_a)
  );

  fwd_pick u_pick_b (
    .rs       (id_rs2),
    .use_alt  (id_b_imm),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (pick_b),
    .load_hit (load_hit_b)
  );

  // Load-use hazard: operand needs a load result that is still in EX
  always_comb begin
    stall  = id_valid && !flush && (load_hit_a || load_hit_b);
    bubble = flush || stall || !id_valid;
  end

  // Next-state for the slots and selects; everything holds under freeze
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!freeze) begin
      mem_d = ex_q;
      if (bubble) begin
        ex_d    = '0;
        sel_a_d = FWD_RF;
        sel_b_d = FWD_RF;
      end else begin
        ex_d.valid   = 1'b1;
        ex_d.rd      = id_rd;
        ex_d.wen     = id_wen;
        ex_d.is_load = id_is_load;
        sel_a_d      = pick_a;
        sel_b_d      = pick_b;
      end
    end
  end

  // Pipeline tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign ex_valid  = ex_q.valid;
  assign fwd_sel_a = sel_a_q;
  assign fwd_sel_b = sel_b_q;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] stat_stalls_q, stat_stalls_d;
  logic [CNT_W-1:0] stat_fwds_q, stat_fwds_d;
  logic [1:0]       fwd_cnt;

  // Count stall cycles and forwarded operands on real advances; wraps freely
  always_comb begin
    stat_stalls_d = stat_stalls_q;
    stat_fwds_d   = stat_fwds_q;
    fwd_cnt       = {1'b0, is_fwd(pick_a)} + {1'b0, is_fwd(pick_b)};
    if (!freeze) begin
      if (stall) begin
        stat_stalls_d = stat_stalls_q + CNT_W'(1);
      end
      if (!bubble) begin
        stat_fwds_d = stat_fwds_q + CNT_W'(fwd_cnt);
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stalls_q <= '0;
      stat_fwds_q   <= '0;
    end else begin
      stat_stalls_q <= stat_stalls_d;
      stat_fwds_q   <= stat_fwds_d;
    end
  end

  assign stat_stalls = stat_stalls_q;
  assign stat_fwds   = stat_fwds_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed table-driven bench for fwd_ctrl, plus hand-written sequences for
// reset mid-stall and (with FWD_STATS_EN) the statistics counters.
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze, flush, id_valid, id_wen, id_is_load, id_a_pc, id_b_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, ex_valid;
  logic [1:0] fwd_sel_a, fwd_sel_b;
`ifdef FWD_STATS_EN
  logic [31:0] stat_stalls, stat_fwds;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_wen     (id_wen),
    .id_is_load (id_is_load),
    .id_a_pc    (id_a_pc),
    .id_b_imm   (id_b_imm),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b)
`ifdef FWD_STATS_EN
    ,
    .stat_stalls(stat_stalls),
    .stat_fwds  (stat_fwds)
`endif
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       wen, ld, apc, bimm, fl, fz;
    logic       e_stall, e_exv;
    logic [1:0] e_sa, e_sb;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic wen, input logic ld,
                      input logic apc, input logic bimm, input logic fl, input logic fz,
                      input logic e_stall, input logic e_exv,
                      input logic [1:0] e_sa, input logic [1:0] e_sb);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.wen = wen; t.ld = ld;
    t.apc = apc; t.bimm = bimm; t.fl = fl; t.fz = fz;
    t.e_stall = e_stall; t.e_exv = e_exv; t.e_sa = e_sa; t.e_sb = e_sb;
    vecs.push_back(t);
  endtask

  task automatic nop();
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
    id_wen = t.wen; id_is_load = t.ld; id_a_pc = t.apc; id_b_imm = t.bimm;
    flush = t.fl; freeze = t.fz;
  endtask

  task automatic idle();
    vec_t t;
    t = '{default: '0};
    drive(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t t;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 0, stall, 0);
    chk("rst_exv", 0, ex_valid, 0);
    chk("rst_sa", 0, fwd_sel_a, 0);
    chk("rst_sb", 0, fwd_sel_b, 0);
`ifdef FWD_STATS_EN
    chk("rst_stat_stalls", 0, stat_stalls, 0);
    chk("rst_stat_fwds", 0, stat_fwds, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    //    v rs1 rs2 rd wen ld apc imm fl fz | stall exv sa sb
    // EX->EX forward: ADD x5 ; ADD x6,x5,x1
    push(1, 1, 2, 5, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    push(1, 5, 1, 6, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0);
    nop(); nop();
    // MEM forward: ADD x5 ; NOP ; SUB x7,x2,x5
    push(1, 1, 2, 5, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    nop();
    push(1, 2, 5, 7, 1, 0, 0, 0, 0, 0,  0, 1, 0, 2);
    nop(); nop();
    // EX priority over MEM: ADD x5 ; ADD x5 ; ADD x8,x5,x5
    push(1, 1, 2, 5, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    push(1, 1, 2, 5, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    push(1, 5, 5, 8, 1, 0, 0, 0, 0, 0,  0, 1, 1, 1);
    nop(); nop();
    // Load-use: LW x3 ; ADD x4,x3,x3 (stall, bubble, then MEM/WB)
    push(1, 1, 0, 3, 1, 1, 0, 1, 0, 0,  0, 1, 0, 3);
    push(1, 3, 3, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    push(1, 3, 3, 4, 1, 0, 0, 0, 0, 0,  0, 1, 2, 2);
    nop(); nop();
    // x0 is never forwarded
    push(1, 1, 2, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    push(1, 0, 0, 9, 1, 0, 0, 1, 0, 0,  0, 1, 0, 3);
    nop(); nop();
    push(1, 1, 0, 0, 1, 1, 0, 1, 0, 0,  0, 1, 0, 3);
    push(1, 0, 0, 9, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    nop(); nop();
    // Load-use with flush: no stall, bubble
    push(1, 1, 0, 3, 1, 1, 0, 1, 0, 0,  0, 1, 0, 3);
    push(1, 3, 3, 4, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0);
    nop(); nop();
    // Operand A is PC: load in EX does not stall
    push(1, 1, 0, 3, 1, 1, 0, 1, 0, 0,  0, 1, 0, 3);
    push(1, 3, 9, 4, 1, 0, 1, 0, 0, 0,  0, 1, 3, 0);
    nop(); nop();
    // Back-to-back loads to x3, each consumer stalls once
    push(1, 1, 0, 3, 1, 1, 0, 1, 0, 0,  0, 1, 0, 3);
    push(1, 3, 1, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    push(1, 3, 1, 4, 1, 0, 0, 0, 0, 0,  0, 1, 2, 0);
    push(1, 1, 0, 3, 1, 1, 0, 1, 0, 0,  0, 1, 0, 3);
    push(1, 3, 2, 5, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    push(1, 3, 2, 5, 1, 0, 0, 0, 0, 0,  0, 1, 2, 0);
    nop(); nop();
    // Freeze for 3 cycles during a hazard: everything holds, stall stays up
    push(1, 1, 0, 3, 1, 1, 0, 1, 0, 0,  0, 1, 0, 3);
    push(1, 3, 3, 4, 1, 0, 0, 0, 0, 1,  1, 1, 0, 3);
    push(1, 3, 3, 4, 1, 0, 0, 0, 0, 1,  1, 1, 0, 3);
    push(1, 3, 3, 4, 1, 0, 0, 0, 0, 1,  1, 1, 0, 3);
    push(1, 3, 3, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    push(1, 3, 3, 4, 1, 0, 0, 0, 0, 0,  0, 1, 2, 2);
    nop(); nop();

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk("stall", i, stall, vecs[i].e_stall);
      @(posedge clk); #1;
      chk("ex_valid", i, ex_valid, vecs[i].e_exv);
      chk("sel_a", i, fwd_sel_a, vecs[i].e_sa);
      chk("sel_b", i, fwd_sel_b, vecs[i].e_sb);
    end

`ifdef FWD_STATS_EN
    // Statistics over a single load-use episode from a clean start
    do_reset();
    t = '{default: '0};
    t.v = 1; t.rs1 = 1; t.rd = 3; t.wen = 1; t.ld = 1; t.bimm = 1;
    drive(t);
    @(posedge clk); #1;
    @(negedge clk);
    t = '{default: '0};
    t.v = 1; t.rs1 = 3; t.rs2 = 3; t.rd = 4; t.wen = 1;
    drive(t);
    repeat (2) @(posedge clk);
    #1;
    chk("stat_stalls", 0, stat_stalls, 1);
    chk("stat_fwds", 0, stat_fwds, 2);
`endif

    // Reset asserted while a load-use stall is active
    do_reset();
    t = '{default: '0};
    t.v = 1; t.rs1 = 1; t.rd = 3; t.wen = 1; t.ld = 1; t.bimm = 1;
    drive(t);
    @(posedge clk); #1;
    @(negedge clk);
    t = '{default: '0};
    t.v = 1; t.rs1 = 3; t.rs2 = 3; t.rd = 4; t.wen = 1;
    drive(t);
    #1;
    chk("midrst_stall_before", 0, stall, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_stall_after", 0, stall, 0);
    chk("midrst_exv", 0, ex_valid, 0);
    chk("midrst_sa", 0, fwd_sel_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_exv", 0, ex_valid, 1);
    chk("restart_sa", 0, fwd_sel_a, 0);
    chk("restart_sb", 0, fwd_sel_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so the bench always terminates
  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
